// File: rtl/axi_sram_arbiter.sv
// axi_sram_arbiter
// Bridges the instruction-fetch and data SRAM-like masters onto one AXI3 master port.
// Reads: one outstanding at a time. Data reads have priority over instruction reads.
// Writes: one outstanding store, sequenced independently of reads.
// A read is held off while it targets the word of the in-flight store.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   inst_sram_*         fetch request (read only) and its accept/completion/data
//   data_sram_*         load/store request and its accept/completion/data
//   ar*, r*             AXI read address / read data channels
//   aw*, w*, b*         AXI write address / write data / write response channels
module axi_sram_arbiter (
  input  logic        clk,
  input  logic        reset,
  // instruction SRAM-like port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data SRAM-like port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {RIdle, RAr, RR} r_state_e;
  typedef enum logic [1:0] {WIdle, WAw, WB} w_state_e;

  r_state_e    r_state_q;
  logic [31:0] r_addr_q;
  logic [1:0]  r_size_q;
  logic        r_id_q;

  w_state_e    w_state_q;
  logic [31:0] w_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  w_size_q;
  logic        awvalid_q;
  logic        wvalid_q;

  logic        w_busy;
  logic        data_rd_req, data_wr_req;
  logic        data_rd_hit, inst_rd_hit;
  logic        data_rd_acc, inst_rd_acc, data_wr_acc;
  logic        rd_ret, rd_ret_data;
  logic        b_fire;
  logic [3:0]  new_strb;
  logic        aw_done, w_done;

  // Status fields and the unused fetch write strobe carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, rresp, rlast, bid, bresp};

  // Request decode and read-after-write hazard (word granularity).
  always_comb begin
    w_busy      = (w_state_q != WIdle);
    data_rd_req = data_sram_req & ~data_sram_wr;
    data_wr_req = data_sram_req & data_sram_wr;
    data_rd_hit = w_busy & (data_sram_addr[31:2] == w_addr_q[31:2]);
    inst_rd_hit = w_busy & (inst_sram_addr[31:2] == w_addr_q[31:2]);
    data_rd_acc = (r_state_q == RIdle) & data_rd_req & ~data_rd_hit;
    // A blocked data read does not stall the fetch port.
    inst_rd_acc = (r_state_q == RIdle) & inst_sram_req & ~inst_rd_hit & ~data_rd_acc;
    data_wr_acc = (w_state_q == WIdle) & data_wr_req;
  end

  always_comb begin
    unique case (data_sram_size)
      2'd0:    new_strb = 4'b0001 << data_sram_addr[1:0];
      2'd1:    new_strb = 4'b0011 << data_sram_addr[1:0];
      default: new_strb = 4'b1111;
    endcase
  end

  always_comb begin
    rd_ret      = (r_state_q == RR) & rvalid;
    rd_ret_data = rd_ret & (rid == 4'd1);
    // Hold off the write response while a data read returns, so the data port
    // never sees two completions in one cycle.
    bready      = (w_state_q == WB) & ~rd_ret_data;
    b_fire      = bvalid & bready;
    aw_done     = ~awvalid_q | awready;
    w_done      = ~wvalid_q | wready;
  end

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc | data_wr_acc;
  assign inst_sram_data_ok = rd_ret & (rid == 4'd0);
  assign data_sram_data_ok = rd_ret_data | b_fire;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  // Read channel outputs
  assign arid    = {3'b000, r_id_q};
  assign araddr  = r_addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state_q == RAr);
  assign rready  = (r_state_q == RR);

  // Write channel outputs
  assign awid    = 4'd1;
  assign awaddr  = w_addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, w_size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;
  assign wid     = 4'd1;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;

  // Read FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= RIdle;
      r_addr_q  <= 32'd0;
      r_size_q  <= 2'd0;
      r_id_q    <= 1'b0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (data_rd_acc) begin
            r_addr_q  <= data_sram_addr;
            r_size_q  <= data_sram_size;
            r_id_q    <= 1'b1;
            r_state_q <= RAr;
          end else if (inst_rd_acc) begin
            r_addr_q  <= inst_sram_addr;
            r_size_q  <= inst_sram_size;
            r_id_q    <= 1'b0;
            r_state_q <= RAr;
          end
        end
        RAr: if (arready) r_state_q <= RR;
        RR:  if (rvalid) r_state_q <= RIdle;
        default: r_state_q <= RIdle;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= WIdle;
      w_addr_q  <= 32'd0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      w_size_q  <= 2'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (data_wr_acc) begin
            w_addr_q  <= data_sram_addr;
            w_data_q  <= data_sram_wdata;
            w_strb_q  <= new_strb;
            w_size_q  <= data_sram_size;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state_q <= WAw;
          end
        end
        WAw: begin
          // AW and W handshakes complete independently, in either order.
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) w_state_q <= WB;
        end
        WB: if (b_fire) w_state_q <= WIdle;
        default: w_state_q <= WIdle;
      endcase
    end
  end

endmodule
